// File: rtl/byte_lane_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_packer_if
// Brief    : Byte-write input and packed-word output bundle of the packer.
// Revision : 1.0 - initial release
// ============================================================================
interface byte_lane_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_lane;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic [1:0]  byteena;

    // Producer of bytes / consumer of words
    modport master (
        output in_valid, in_data, in_lane, in_last, out_ready,
        input  in_ready, out_valid, d, byteena
    );

    // The packer itself
    modport slave (
        input  in_valid, in_data, in_lane, in_last, out_ready,
        output in_ready, out_valid, d, byteena
    );
endinterface
`default_nettype wire

// File: rtl/byte_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_packer
// Brief    : Packs single-byte writes into a 16-bit word with byte enables.
//            Optional idle flush of partial words: define FLUSH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module byte_lane_packer #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    byte_lane_packer_if.slave   bus
);

    logic [15:0] r_stg_data;
    logic [1:0]  r_stg_en;
    logic        r_stg_done;
    logic        r_out_valid;
    logic [15:0] r_d;
    logic [1:0]  r_byteena;

    logic [15:0] w_nxt_stg_data;
    logic [1:0]  w_nxt_stg_en;
    logic        w_nxt_stg_done;
    logic        w_load;
    logic [15:0] w_load_d;
    logic [1:0]  w_load_en;

    logic        w_slot_free;
    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_out_fire;
    logic [1:0]  w_lane_bit;
    logic [15:0] w_lane_data;
    logic [1:0]  w_merged_en;
    logic [15:0] w_merged_data;

    assign w_slot_free   = !r_out_valid || bus.out_ready;
    assign w_in_ready    = !r_stg_done && ((r_stg_en == 2'b00) || w_slot_free);
    assign w_in_fire     = bus.in_valid && w_in_ready;
    assign w_out_fire    = r_out_valid && bus.out_ready;
    assign w_lane_bit    = bus.in_lane ? 2'b10 : 2'b01;
    assign w_lane_data   = bus.in_lane ? {bus.in_data, 8'h00} : {8'h00, bus.in_data};
    // Disabled staging lanes are always zero, so a plain OR merges correctly
    assign w_merged_en   = r_stg_en | w_lane_bit;
    assign w_merged_data = r_stg_data | w_lane_data;

`ifdef FLUSH_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_nxt_cnt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        w_nxt_stg_data = r_stg_data;
        w_nxt_stg_en   = r_stg_en;
        w_nxt_stg_done = r_stg_done;
        w_load         = 1'b0;
        w_load_d       = r_stg_data;
        w_load_en      = r_stg_en;

        if (w_in_fire) begin
            if ((r_stg_en & w_lane_bit) != 2'b00) begin
                // Collision: push out the old word, restart staging with this byte
                w_load         = 1'b1;
                w_nxt_stg_data = w_lane_data;
                w_nxt_stg_en   = w_lane_bit;
                w_nxt_stg_done = bus.in_last;
            end else if ((w_merged_en == 2'b11) || bus.in_last) begin
                if (w_slot_free) begin
                    w_load         = 1'b1;
                    w_load_d       = w_merged_data;
                    w_load_en      = w_merged_en;
                    w_nxt_stg_data = 16'h0000;
                    w_nxt_stg_en   = 2'b00;
                    w_nxt_stg_done = 1'b0;
                end else begin
                    w_nxt_stg_data = w_merged_data;
                    w_nxt_stg_en   = w_merged_en;
                    w_nxt_stg_done = 1'b1;
                end
            end else begin
                w_nxt_stg_data = w_merged_data;
                w_nxt_stg_en   = w_merged_en;
            end
        end else if (r_stg_done && w_slot_free) begin
            w_load         = 1'b1;
            w_nxt_stg_data = 16'h0000;
            w_nxt_stg_en   = 2'b00;
            w_nxt_stg_done = 1'b0;
        end

`ifdef FLUSH_TIMEOUT_EN
        w_nxt_cnt = '0;
        if (!w_in_fire && (r_stg_en != 2'b00) && !r_stg_done) begin
            if (r_cnt == c_CNT_LAST) begin
                w_nxt_stg_done = 1'b1;
            end else begin
                w_nxt_cnt = r_cnt + c_CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg_data  <= 16'h0000;
            r_stg_en    <= 2'b00;
            r_stg_done  <= 1'b0;
            r_out_valid <= 1'b0;
            r_d         <= 16'h0000;
            r_byteena   <= 2'b00;
        end else begin
            r_stg_data <= w_nxt_stg_data;
            r_stg_en   <= w_nxt_stg_en;
            r_stg_done <= w_nxt_stg_done;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_d         <= w_load_d;
                r_byteena   <= w_load_en;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef FLUSH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt_cnt;
        end
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.d         = r_d;
    assign bus.byteena   = r_byteena;

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_lane_packer
// Brief    : Scoreboard bench for byte_lane_packer (directed + random traffic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_lane_packer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    byte_lane_packer_if ifc ();

    byte_lane_packer #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic        rnd      = 1'b0;
    logic [17:0] sb[$];
    logic [15:0] m_d  = 16'h0000;
    logic [1:0]  m_en = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference packing model: pushes each completed word to the scoreboard
    task automatic model_byte(input logic lane, input logic [7:0] data, input logic last);
        logic [1:0]  lb;
        logic [15:0] bd;
        lb = lane ? 2'b10 : 2'b01;
        bd = lane ? {data, 8'h00} : {8'h00, data};
        if ((m_en & lb) != 2'b00) begin
            sb.push_back({m_d, m_en});
            m_en = lb;
            m_d  = bd;
        end else begin
            m_en = m_en | lb;
            m_d  = m_d | bd;
        end
        if (last || m_en == 2'b11) begin
            sb.push_back({m_d, m_en});
            m_en = 2'b00;
            m_d  = 16'h0000;
        end
    endtask

    task automatic send_byte(input logic lane, input logic [7:0] data, input logic last);
        int   n;
        logic fired;
        n = 0;
        fired = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_lane  = lane;
        ifc.in_data  = data;
        ifc.in_last  = last;
        while (!fired && n < 100) begin
            @(negedge clk);
            fired = ifc.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        ifc.in_valid = 1'b0;
        if (fired) model_byte(lane, data, last);
        else chk("in_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ifc.out_valid || sb.size() > 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    always @(posedge clk) cyc++;

    // Consumer back-pressure never stalls two cycles in a row
    always @(posedge clk) begin
        if (rnd) begin
            #1;
            ifc.out_ready = (ifc.out_ready == 1'b0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        if (!reset && ifc.out_valid) begin
            if (ifc.byteena == 2'b00) chk("byteena_nonzero", ifc.byteena, 2'b11);
            if (ifc.out_ready) begin
                chk("sb_has_entry", (sb.size() > 0), 1);
                if (sb.size() > 0) chk("out_word", {ifc.d, ifc.byteena}, sb.pop_front());
            end
        end
    end

    initial begin
        logic flag;
        int   c0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 8'h00;
        ifc.in_lane   = 1'b0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_d", ifc.d, 16'h0000);
        chk("rst_byteena", ifc.byteena, 2'b00);
        chk("rst_in_ready", ifc.in_ready, 1);

        // Two lanes -> full word, one-cycle latency, one-cycle pulse
        send_byte(1'b0, 8'h67, 1'b0);
        send_byte(1'b1, 8'h45, 1'b0);
        chk("lat_out_valid", ifc.out_valid, 1);
        chk("lat_d", ifc.d, 16'h4567);
        chk("lat_byteena", ifc.byteena, 2'b11);
        @(posedge clk);
        #1;
        chk("pulse_end", ifc.out_valid, 0);

        send_byte(1'b1, 8'h37, 1'b1);
        wait_idle();

        // Collision emits the first byte, the second stays staged
        send_byte(1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 8'h22, 1'b0);
        wait_idle();
        send_byte(1'b1, 8'h99, 1'b0);
        wait_idle();

        // Back-pressure hold
        ifc.out_ready = 1'b0;
        send_byte(1'b0, 8'hCD, 1'b0);
        send_byte(1'b1, 8'hAB, 1'b0);
        send_byte(1'b0, 8'hEF, 1'b0);
        chk("hold_in_ready", ifc.in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_d", ifc.d, 16'hABCD);
            chk("hold_byteena", ifc.byteena, 2'b11);
            chk("hold_valid", ifc.out_valid, 1);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid", ifc.out_valid, 0);
        chk("drain_in_ready", ifc.in_ready, 1);
        send_byte(1'b1, 8'h01, 1'b1);
        wait_idle();

        // Reset drops a partial word
        send_byte(1'b0, 8'h55, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_en = 2'b00;
        m_d  = 16'h0000;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            flag = flag | ifc.out_valid;
        end
        chk("reset_no_emit", flag, 0);
        chk("reset_in_ready", ifc.in_ready, 1);
        send_byte(1'b1, 8'h77, 1'b1);
        wait_idle();

        // Idle partial word
        send_byte(1'b1, 8'h9A, 1'b0);
`ifdef FLUSH_TIMEOUT_EN
        sb.push_back({m_d, m_en});
        m_en = 2'b00;
        m_d  = 16'h0000;
        c0 = 0;
        while (!ifc.out_valid && c0 < 20) begin
            @(posedge clk);
            #1;
            c0++;
        end
        chk("timeout_flush", ifc.out_valid, 1);
        wait_idle();
`else
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            flag = flag | ifc.out_valid;
        end
        chk("no_timeout_flush", flag, 0);
        send_byte(1'b0, 8'hBC, 1'b1);
        wait_idle();
`endif

        // Throughput: one byte per cycle
        c0 = cyc;
        for (int i = 0; i < 6; i++) send_byte(i[0], 8'($urandom), 1'b0);
        chk("throughput_cycles", cyc - c0, 6);
        wait_idle();

        // Random traffic with back-pressure
        rnd = 1'b1;
        for (int i = 0; i < 60; i++)
            send_byte(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        rnd = 1'b0;
        #2 ifc.out_ready = 1'b1;
        send_byte(1'b0, 8'h5A, 1'b1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
